// File: rtl/pc_npc_unit_pkg.sv
// Shared definitions for the fetch-stage PC/nPC unit.
//   pc_state_e  : delay-slot tracking FSM states
//   Def*        : default address width, sequential step and reset/trap vectors
package pc_pkg;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_SLOT = 1'b1
  } pc_state_e;

  localparam int unsigned DefWidth     = 32;
  localparam logic [31:0] DefStep      = 32'd4;
  localparam logic [31:0] DefResetVec  = 32'h0000_0000;
  localparam logic [31:0] DefTrapVec   = 32'h0000_0080;
  localparam int unsigned DefHistDepth = 8;

endpackage

// File: rtl/pc_npc_unit_if.sv
// Control and status bundle of the PC/nPC unit.
//   master : fetch/decode side, drives le, branch_taken/branch_target, trap, hist_rd_idx
//   slave  : the PC/nPC unit, drives pc_out, npc_out, in_slot, slot_br_err, hist_rd_data,
//            hist_count
interface pc_npc_unit_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned HIST_DEPTH = 8
);
  localparam int unsigned IdxW = $clog2(HIST_DEPTH);

  logic              le;
  logic              branch_taken;
  logic [WIDTH-1:0]  branch_target;
  logic              trap;
  logic [WIDTH-1:0]  pc_out;
  logic [WIDTH-1:0]  npc_out;
  logic              in_slot;
  logic              slot_br_err;
  logic [IdxW-1:0]   hist_rd_idx;
  logic [WIDTH-1:0]  hist_rd_data;
  logic [IdxW:0]     hist_count;

  modport master (
    output le, branch_taken, branch_target, trap, hist_rd_idx,
    input  pc_out, npc_out, in_slot, slot_br_err, hist_rd_data, hist_count
  );

  modport slave (
    input  le, branch_taken, branch_target, trap, hist_rd_idx,
    output pc_out, npc_out, in_slot, slot_br_err, hist_rd_data, hist_count
  );

endinterface

// File: rtl/pc_hist_buf.sv
// Circular history of retired PC values.
//   clk, reset   : clock, asynchronous active-high reset (clears all entries)
//   push_i       : write push_data_i into the newest slot, overwriting the oldest when full
//   rd_idx_i     : 0 = newest entry; indices at or beyond count_o read as zero
//   rd_data_o    : combinational read data
//   count_o      : valid entries, saturates at DEPTH
module pc_hist_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IdxW-1:0]  wptr_q, wptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [IdxW-1:0]  rd_ptr;

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    if (push_i) begin
      // DEPTH is a power of two, so the pointer wraps naturally.
      wptr_d = wptr_q + IdxW'(1);
      if (count_q != CntW'(DEPTH)) count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
      if (push_i) mem_q[wptr_q] <= push_data_i;
    end
  end

  // Newest entry sits one behind the write pointer.
  assign rd_ptr    = wptr_q - IdxW'(1) - rd_idx_i;
  assign rd_data_o = ({1'b0, rd_idx_i} < count_q) ? mem_q[rd_ptr] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/pc_npc_unit.sv
// Fetch-stage PC/nPC register pair with delayed-branch sequencing.
// The delay-slot instruction always executes; a taken branch in the slot is dropped and
// flagged with a one-cycle slot_br_err pulse. trap overrides stall; le=0 holds everything.
// Optional macro PC_HIST_EN adds a retired-PC history buffer (pc_hist_buf); without it the
// history outputs read as zero.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pc_npc_unit_if slave (le, branch_taken, branch_target, trap, pc_out, npc_out,
//                in_slot, slot_br_err, hist_rd_idx, hist_rd_data, hist_count)
module pc_npc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = DefWidth,
  parameter logic [WIDTH-1:0] STEP       = WIDTH'(DefStep),
  parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(DefResetVec),
  parameter logic [WIDTH-1:0] TRAP_VEC   = WIDTH'(DefTrapVec),
  parameter int unsigned      HIST_DEPTH = DefHistDepth
) (
  input  logic          clk,
  input  logic          reset,
  pc_npc_unit_if.slave  bus
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic             slot_err_q, slot_err_d;
  logic             pc_update;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_VEC;
      npc_q      <= RESET_VEC + STEP;
      slot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      slot_err_q <= slot_err_d;
    end
  end

  // Next-state logic: trap > stall > normal sequencing.
  always_comb begin
    state_d = state_q;
    if (bus.trap) begin
      state_d = S_RUN;
    end else if (bus.le) begin
      unique case (state_q)
        S_RUN:   state_d = bus.branch_taken ? S_SLOT : S_RUN;
        S_SLOT:  state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  // PC/nPC datapath and dropped-branch detection.
  always_comb begin
    pc_d       = pc_q;
    npc_d      = npc_q;
    slot_err_d = 1'b0;
    if (bus.trap) begin
      pc_d  = TRAP_VEC;
      npc_d = TRAP_VEC + STEP;
    end else if (bus.le) begin
      pc_d = npc_q;
      if (state_q == S_RUN && bus.branch_taken) begin
        npc_d = bus.branch_target;
      end else begin
        npc_d = npc_q + STEP;
      end
      // A branch resolved inside the delay slot cannot be honoured.
      slot_err_d = (state_q == S_SLOT) && bus.branch_taken;
    end
  end

  // Outputs.
  always_comb begin
    bus.pc_out      = pc_q;
    bus.npc_out     = npc_q;
    bus.in_slot     = (state_q == S_SLOT);
    bus.slot_br_err = slot_err_q;
  end

  assign pc_update = bus.trap | bus.le;

`ifdef PC_HIST_EN
  pc_hist_buf #(
    .WIDTH (WIDTH),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk         (clk),
    .reset       (reset),
    .push_i      (pc_update),
    .push_data_i (pc_q),
    .rd_idx_i    (bus.hist_rd_idx),
    .rd_data_o   (bus.hist_rd_data),
    .count_o     (bus.hist_count)
  );
`else
  logic unused_hist;
  assign unused_hist      = pc_update ^ (^bus.hist_rd_idx);
  assign bus.hist_rd_data = '0;
  assign bus.hist_count   = '0;
`endif

endmodule
